proc_frame_ctrl: RTL and testbench

Frame-level controller for the `image_process` datapath. It arms on a start command, aligns to the video frame boundary and gates the incoming `vs`/`de` stream into the pipeline for a programmed number of frames. It supplies aligned `xpos`/`ypos` and double-buffers the mode/threshold configuration so that values change only between frames. It sits between `img_gen` (or the camera front end) and `image_process`.

---
 rtl/proc_ctrl_pkg.sv | 24 ++
 rtl/proc_geom_chk.sv | 63 ++++++
 rtl/proc_frame_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_proc_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the frame controller: FSM encoding, config addresses,
// default geometry and the position widths derived from it.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] CFG_MODE   = 2'd0;
  localparam logic [1:0] CFG_THRESH = 2'd1;

  localparam int DEF_IW = 640;
  localparam int DEF_IH = 480;
  localparam int XPOS_W = $clog2(DEF_IW);
  localparam int YPOS_W = $clog2(DEF_IH);

  // Frame counter holds at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/proc_geom_chk.sv
// Sticky geometry checker: flags any line whose length is not ACTIVE_IW or any frame whose
// line count is not ACTIVE_IH while the controller is running; error cleared by clr.
module proc_geom_chk
  import proc_ctrl_pkg::*;
#(
  parameter int ACTIVE_IW = DEF_IW,
  parameter int ACTIVE_IH = DEF_IH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic de,
  input  logic de_fall,
  input  logic vs_rise,
  input  logic run,
  input  logic first_frame,
  input  logic clr,
  output logic geom_err
);

  localparam int XCW = $clog2(ACTIVE_IW + 1);
  localparam int YCW = $clog2(ACTIVE_IH + 1);
  localparam logic [XCW-1:0] IW_C = XCW'(ACTIVE_IW);
  localparam logic [YCW-1:0] IH_C = YCW'(ACTIVE_IH);

  logic [XCW-1:0] x_cnt_q, x_cnt_d;
  logic [YCW-1:0] y_cnt_q, y_cnt_d;
  logic           err_q, err_d;

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    err_d   = err_q;

    if (de)           x_cnt_d = x_cnt_q + XCW'(1);
    else if (de_fall) x_cnt_d = '0;

    if (vs_rise)      y_cnt_d = '0;
    else if (de_fall) y_cnt_d = y_cnt_q + YCW'(1);

    if (clr) begin
      err_d = 1'b0;
    end else if (run) begin
      if (de_fall && (x_cnt_q != IW_C)) err_d = 1'b1;
      // The sync that enters RUN closes a partial frame, so its line count means nothing.
      if (vs_rise && !first_frame && (y_cnt_q != IH_C)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      err_q   <= err_d;
    end
  end

  assign geom_err = err_q;

endmodule

// File: rtl/proc_frame_ctrl.sv
// Frame controller: arms on start, aligns to vsync, gates de for frame_num frames (0 = forever).
// Outputs are 1 cycle behind the inputs; no backpressure. PROC_CTRL_GEOM_CHK_EN builds the geometry checker.
module proc_frame_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int         ACTIVE_IW  = DEF_IW,
  parameter int         ACTIVE_IH  = DEF_IH,
  parameter logic [1:0] DEF_MODE   = 2'd0,
  parameter logic [7:0] DEF_THRESH = 8'd150
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pre_frame_vsync,
  input  logic                         pre_frame_de,
  input  logic                         start,
  input  logic                         stop,
  input  logic [7:0]                   frame_num,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [7:0]                   cfg_wdata,
  output logic                         proc_vsync,
  output logic                         proc_de,
  output logic [$clog2(ACTIVE_IW)-1:0] xpos,
  output logic [$clog2(ACTIVE_IH)-1:0] ypos,
  output logic [1:0]                   mode,
  output logic [7:0]                   threshold,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         all_done,
  output logic [7:0]                   frame_cnt,
  output logic                         geom_err
);

  localparam int XW  = $clog2(ACTIVE_IW);
  localparam int YW  = $clog2(ACTIVE_IH);
  // Counters need one extra code so a full line/frame count is representable.
  localparam int XCW = $clog2(ACTIVE_IW + 1);
  localparam int YCW = $clog2(ACTIVE_IH + 1);

  state_t         state_q, state_d;
  logic           vs_r_q, de_r_q;
  logic [XCW-1:0] x_cnt_q, x_cnt_d;
  logic [YCW-1:0] y_cnt_q, y_cnt_d;
  logic           proc_vsync_q, proc_vsync_d;
  logic           proc_de_q, proc_de_d;
  logic [XW-1:0]  xpos_q, xpos_d;
  logic [YW-1:0]  ypos_q, ypos_d;
  logic           frame_done_q, frame_done_d;
  logic           all_done_q, all_done_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           stop_req_q, stop_req_d;
  logic [1:0]     mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
  logic [7:0]     thr_sh_q, thr_sh_d, thr_act_q, thr_act_d;

  logic vs_rise, de_fall, start_ok;

  assign vs_rise  = pre_frame_vsync & ~vs_r_q;
  assign de_fall  = ~pre_frame_de & de_r_q;
  assign start_ok = (state_q == ST_IDLE) & start & ~stop;

  // Pixel/line counters and the aligned datapath outputs.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;

    if (pre_frame_de) x_cnt_d = x_cnt_q + XCW'(1);
    else if (de_fall) x_cnt_d = '0;

    if (vs_rise)      y_cnt_d = '0;
    else if (de_fall) y_cnt_d = y_cnt_q + YCW'(1);

    proc_vsync_d = pre_frame_vsync;
    proc_de_d    = pre_frame_de & (state_q == ST_RUN);
    xpos_d       = x_cnt_q[XW-1:0];
    ypos_d       = y_cnt_q[YW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    all_done_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    stop_req_d   = stop_req_q;

    case (state_q)
      ST_IDLE: begin
        stop_req_d = 1'b0;
        if (start_ok) begin
          state_d     = ST_ARM;
          frame_cnt_d = '0;
        end
      end
      ST_ARM: begin
        if (stop)         state_d = ST_IDLE;
        else if (vs_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) stop_req_d = 1'b1;
        if (vs_rise) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = sat_inc8(frame_cnt_q);
          // A stop landing on the closing sync counts as pending for that frame.
          if (((frame_num != 8'd0) && (frame_cnt_d == frame_num)) || stop_req_q || stop) begin
            all_done_d = 1'b1;
            state_d    = ST_IDLE;
            stop_req_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config shadows; active copies only move at frame boundaries once armed.
  always_comb begin
    mode_sh_d  = mode_sh_q;
    thr_sh_d   = thr_sh_q;
    mode_act_d = mode_act_q;
    thr_act_d  = thr_act_q;

    if (cfg_we) begin
      case (cfg_addr)
        CFG_MODE:   mode_sh_d = cfg_wdata[1:0];
        CFG_THRESH: thr_sh_d  = cfg_wdata;
        default: ;
      endcase
    end

    if (state_q == ST_IDLE) begin
      mode_act_d = mode_sh_d;
      thr_act_d  = thr_sh_d;
    end else if (vs_rise) begin
      mode_act_d = mode_sh_q;
      thr_act_d  = thr_sh_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vs_r_q       <= 1'b0;
      de_r_q       <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      proc_vsync_q <= 1'b0;
      proc_de_q    <= 1'b0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      frame_done_q <= 1'b0;
      all_done_q   <= 1'b0;
      frame_cnt_q  <= '0;
      stop_req_q   <= 1'b0;
      mode_sh_q    <= DEF_MODE;
      mode_act_q   <= DEF_MODE;
      thr_sh_q     <= DEF_THRESH;
      thr_act_q    <= DEF_THRESH;
    end else begin
      state_q      <= state_d;
      vs_r_q       <= pre_frame_vsync;
      de_r_q       <= pre_frame_de;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      proc_vsync_q <= proc_vsync_d;
      proc_de_q    <= proc_de_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      frame_done_q <= frame_done_d;
      all_done_q   <= all_done_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_req_q   <= stop_req_d;
      mode_sh_q    <= mode_sh_d;
      mode_act_q   <= mode_act_d;
      thr_sh_q     <= thr_sh_d;
      thr_act_q    <= thr_act_d;
    end
  end

  assign proc_vsync = proc_vsync_q;
  assign proc_de    = proc_de_q;
  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign mode       = mode_act_q;
  assign threshold  = thr_act_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign all_done   = all_done_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef PROC_CTRL_GEOM_CHK_EN
  proc_geom_chk #(
    .ACTIVE_IW (ACTIVE_IW),
    .ACTIVE_IH (ACTIVE_IH)
  ) u_geom_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .de          (pre_frame_de),
    .de_fall     (de_fall),
    .vs_rise     (vs_rise),
    .run         (state_q == ST_RUN),
    .first_frame (state_q == ST_ARM),
    .clr         (start_ok),
    .geom_err    (geom_err)
  );
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_proc_frame_ctrl.sv
// Bench for proc_frame_ctrl on a reduced 12x4 raster with randomized blanking.
module tb_proc_frame_ctrl;

  localparam int IW   = 12;
  localparam int IH   = 4;
  localparam int TXW  = $clog2(IW);
  localparam int TYW  = $clog2(IH);
  localparam int FPIX = IW * IH;
`ifdef PROC_CTRL_GEOM_CHK_EN
  localparam logic EXP_GEOM = 1'b1;
`else
  localparam logic EXP_GEOM = 1'b0;
`endif

  logic           clk, rst_n;
  logic           pre_frame_vsync, pre_frame_de, start, stop;
  logic [7:0]     frame_num;
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [7:0]     cfg_wdata;
  logic           proc_vsync, proc_de, busy, frame_done, all_done, geom_err;
  logic [TXW-1:0] xpos;
  logic [TYW-1:0] ypos;
  logic [1:0]     mode;
  logic [7:0]     threshold, frame_cnt;

  proc_frame_ctrl #(
    .ACTIVE_IW(IW), .ACTIVE_IH(IH), .DEF_MODE(2'd0), .DEF_THRESH(8'd150)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pre_frame_vsync(pre_frame_vsync), .pre_frame_de(pre_frame_de),
    .start(start), .stop(stop), .frame_num(frame_num), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .proc_vsync(proc_vsync), .proc_de(proc_de), .xpos(xpos), .ypos(ypos),
    .mode(mode), .threshold(threshold), .busy(busy), .frame_done(frame_done), .all_done(all_done),
    .frame_cnt(frame_cnt), .geom_err(geom_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;
  int pix_cnt, gate_bad, pos_bad, vs_bad, fd_cnt, ad_cnt, ad_at, vs_idx;
  logic prev_vs = 1'b0;
  logic [7:0] thr_vs, thr_wr;

  task automatic clr_acc();
    pix_cnt = 0; gate_bad = 0; pos_bad = 0; vs_bad = 0;
    fd_cnt = 0; ad_cnt = 0; ad_at = -1; vs_idx = 0;
  endtask

  // One clock of raster; 'pass' says whether this pixel should reach proc_de.
  task automatic step(input logic vs, input logic de, input int x, input int y, input bit pass);
    pre_frame_vsync = vs;
    pre_frame_de    = de;
    if (vs && !prev_vs) vs_idx++;
    prev_vs = vs;
    @(posedge clk); #1;
    if (proc_vsync !== vs) vs_bad++;
    if (proc_de !== (de & pass)) gate_bad++;
    if (de && pass && ((xpos !== TXW'(x)) || (ypos !== TYW'(y)))) pos_bad++;
    if (proc_de === 1'b1) pix_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (all_done === 1'b1) begin ad_cnt++; ad_at = vs_idx; end
  endtask

  // pulse_kind: 1 = stop, 2 = start, at first pixel of pulse_line.
  task automatic frame(input bit pass, input int short_line, input int pulse_line,
                       input int pulse_kind, input int wr_line, input bit wr_at_vs,
                       input logic [7:0] wr_val);
    int len;
    if (wr_at_vs) begin cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = wr_val; end
    step(1'b1, 1'b0, 0, 0, pass);
    cfg_we = 1'b0;
    thr_vs = threshold;
    step(1'b1, 1'b0, 0, 0, pass);
    repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 0, 0, pass);
    for (int y = 0; y < IH; y++) begin
      len = (y == short_line) ? IW - 1 : IW;
      for (int x = 0; x < len; x++) begin
        if (x == 0 && y == pulse_line) begin start = (pulse_kind == 2); stop = (pulse_kind == 1); end
        if (x == 0 && y == wr_line) begin cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = wr_val; end
        step(1'b0, 1'b1, x, y, pass);
        start = 1'b0; stop = 1'b0;
        if (x == 0 && y == wr_line) begin cfg_we = 1'b0; thr_wr = threshold; end
      end
      repeat ($urandom_range(2, 4)) step(1'b0, 1'b0, 0, 0, pass);
    end
  endtask

  task automatic idle_cfg(input logic [1:0] addr, input logic [7:0] val);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = val;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1'b0, 1'b0, 0, 0, 1'b0); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pre_frame_vsync = 1'b0; pre_frame_de = 1'b0; start = 1'b0; stop = 1'b0;
    frame_num = 8'd0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    ncmp++; if ({proc_vsync, proc_de, xpos, ypos, busy, frame_done, all_done, frame_cnt, geom_err} !== '0) begin
      nerr++; $display("FAIL reset_zero: got vs=%b de=%b busy=%b cnt=%0d err=%b expected all 0", proc_vsync, proc_de, busy, frame_cnt, geom_err); end
    ncmp++; if (mode !== 2'd0) begin nerr++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    ncmp++; if (threshold !== 8'd150) begin nerr++; $display("FAIL reset_thresh: got %0d expected 150", threshold); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_idle();
    idle_cfg(2'd1, 8'd200);
    ncmp++; if (threshold !== 8'd200) begin nerr++; $display("FAIL idle_thresh: got %0d expected 200", threshold); end
    idle_cfg(2'd0, 8'hFE);
    ncmp++; if (mode !== 2'd2) begin nerr++; $display("FAIL idle_mode: got %0d expected 2", mode); end
    idle_cfg(2'd2, 8'h55);
    idle_cfg(2'd3, 8'h11);
    ncmp++; if ({mode, threshold} !== {2'd2, 8'd200}) begin
      nerr++; $display("FAIL idle_bad_addr: got mode=%0d thr=%0d expected 2/200", mode, threshold); end
    idle_cfg(2'd1, 8'd150);
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    start = 1'b0; stop = 1'b0;
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL start_stop_same: got busy=%b expected 0", busy); end
  endtask

  task automatic test_frame_num2();
    clr_acc(); frame_num = 8'd2;
    pulse_start();
    ncmp++; if (busy !== 1'b1) begin nerr++; $display("FAIL fn2_busy: got %b expected 1", busy); end
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (pix_cnt != 2 * FPIX) begin nerr++; $display("FAIL fn2_pixels: got %0d expected %0d", pix_cnt, 2 * FPIX); end
    ncmp++; if (fd_cnt != 2) begin nerr++; $display("FAIL fn2_frame_done: got %0d expected 2", fd_cnt); end
    ncmp++; if (ad_cnt != 1 || ad_at != 3) begin nerr++; $display("FAIL fn2_all_done: got %0d pulses at vs %0d expected 1 at 3", ad_cnt, ad_at); end
    ncmp++; if (frame_cnt !== 8'd2) begin nerr++; $display("FAIL fn2_frame_cnt: got %0d expected 2", frame_cnt); end
    ncmp++; if (gate_bad != 0 || pos_bad != 0 || vs_bad != 0) begin
      nerr++; $display("FAIL fn2_stream: got gate=%0d pos=%0d vs=%0d bad cycles expected 0", gate_bad, pos_bad, vs_bad); end
    ncmp++; if (geom_err !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL fn2_end: got err=%b busy=%b expected 0/0", geom_err, busy); end
  endtask

  task automatic test_cfg_stop();
    clr_acc(); frame_num = 8'd0;
    pulse_start();
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b1, -1, -1, 0, 1, 1'b0, 8'd200);
    ncmp++; if (thr_wr !== 8'd150) begin nerr++; $display("FAIL cfg_mid_hold: got %0d expected 150", thr_wr); end
    frame(1'b1, -1, 2, 1, -1, 1'b1, 8'd99);
    ncmp++; if (thr_vs !== 8'd200) begin nerr++; $display("FAIL cfg_vs_copy: got %0d expected 200", thr_vs); end
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (thr_vs !== 8'd99) begin nerr++; $display("FAIL cfg_vs_same_cycle: got %0d expected 99", thr_vs); end
    ncmp++; if (frame_cnt !== 8'd3) begin nerr++; $display("FAIL stop_frame_cnt: got %0d expected 3", frame_cnt); end
    ncmp++; if (ad_cnt != 1 || ad_at != 4) begin nerr++; $display("FAIL stop_all_done: got %0d pulses at vs %0d expected 1 at 4", ad_cnt, ad_at); end
    ncmp++; if (pix_cnt != 3 * FPIX || gate_bad != 0) begin
      nerr++; $display("FAIL stop_pixels: got %0d (gate bad %0d) expected %0d", pix_cnt, gate_bad, 3 * FPIX); end
  endtask

  task automatic test_geom();
    clr_acc(); frame_num = 8'd3;
    pulse_start();
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b1, 2, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (geom_err !== EXP_GEOM) begin nerr++; $display("FAIL geom_set: got %b expected %b", geom_err, EXP_GEOM); end
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (geom_err !== EXP_GEOM || busy !== 1'b0) begin
      nerr++; $display("FAIL geom_sticky: got err=%b busy=%b expected %b/0", geom_err, busy, EXP_GEOM); end
    ncmp++; if (pix_cnt != 3 * FPIX - 1 || pos_bad != 0) begin
      nerr++; $display("FAIL geom_pixels: got %0d (pos bad %0d) expected %0d", pix_cnt, pos_bad, 3 * FPIX - 1); end
    pulse_start();
    ncmp++; if (geom_err !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL geom_clear: got err=%b busy=%b expected 0/1", geom_err, busy); end
    stop = 1'b1; step(1'b0, 1'b0, 0, 0, 1'b0); stop = 1'b0;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    ncmp++; if (busy !== 1'b0 || ad_cnt != 1) begin
      nerr++; $display("FAIL arm_stop: got busy=%b all_done=%0d expected 0/1", busy, ad_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [1:0] m;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 3);
      m = 2'($urandom_range(0, 3));
      idle_cfg(2'd0, {6'd0, m});
      ncmp++; if (mode !== m) begin nerr++; $display("FAIL b2b_mode: got %0d expected %0d", mode, m); end
      clr_acc(); frame_num = 8'(n);
      pulse_start();
      for (int f = 0; f < n; f++) frame(1'b1, -1, (f == 0) ? 1 : -1, 2, -1, 1'b0, 8'd0);
      frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
      ncmp++; if (frame_cnt !== 8'(n) || fd_cnt != n) begin
        nerr++; $display("FAIL b2b_count: got cnt=%0d fd=%0d expected %0d", frame_cnt, fd_cnt, n); end
      ncmp++; if (ad_cnt != 1 || ad_at != n + 1) begin
        nerr++; $display("FAIL b2b_all_done: got %0d at vs %0d expected 1 at %0d", ad_cnt, ad_at, n + 1); end
      ncmp++; if (pix_cnt != n * FPIX || gate_bad != 0 || pos_bad != 0) begin
        nerr++; $display("FAIL b2b_stream: got pix=%0d gate=%0d pos=%0d expected %0d/0/0", pix_cnt, gate_bad, pos_bad, n * FPIX); end
    end
  endtask

  task automatic test_reset_mid_run();
    idle_cfg(2'd1, 8'd77);
    idle_cfg(2'd0, 8'd3);
    clr_acc(); frame_num = 8'd0;
    pulse_start();
    frame(1'b1, -1, -1, 0, -1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 0, 0, 1'b1); step(1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1); step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < IW; x++) step(1'b0, 1'b1, x, y, 1'b1);
      repeat (3) step(1'b0, 1'b0, 0, 0, 1'b1);
    end
    for (int x = 0; x <= 10; x++) step(1'b0, 1'b1, x, 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    ncmp++; if ({proc_vsync, proc_de, xpos, ypos, busy, frame_done, all_done, frame_cnt, geom_err} !== '0) begin
      nerr++; $display("FAIL midrst_zero: got de=%b x=%0d y=%0d busy=%b cnt=%0d expected all 0", proc_de, xpos, ypos, busy, frame_cnt); end
    ncmp++; if (mode !== 2'd0 || threshold !== 8'd150) begin
      nerr++; $display("FAIL midrst_cfg: got mode=%0d thr=%0d expected 0/150", mode, threshold); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr_acc();
    step(1'b0, 1'b1, 11, 3, 1'b0);
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0);
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (pix_cnt != 0 || gate_bad != 0 || busy !== 1'b0) begin
      nerr++; $display("FAIL midrst_gated: got pix=%0d gate=%0d busy=%b expected 0/0/0", pix_cnt, gate_bad, busy); end
  endtask

  task automatic test_saturate();
    clr_acc(); frame_num = 8'd0;
    pulse_start();
    for (int f = 0; f < 257; f++) frame(1'b1, -1, (f == 256) ? 0 : -1, 1, -1, 1'b0, 8'd0);
    frame(1'b0, -1, -1, 0, -1, 1'b0, 8'd0);
    ncmp++; if (frame_cnt !== 8'd255) begin nerr++; $display("FAIL sat_frame_cnt: got %0d expected 255", frame_cnt); end
    ncmp++; if (fd_cnt != 257 || ad_at != 258) begin
      nerr++; $display("FAIL sat_pulses: got fd=%0d all_done at vs %0d expected 257/258", fd_cnt, ad_at); end
    ncmp++; if (pix_cnt != 257 * FPIX || gate_bad != 0) begin
      nerr++; $display("FAIL sat_pixels: got %0d (gate bad %0d) expected %0d", pix_cnt, gate_bad, 257 * FPIX); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_cfg_idle();
    test_start_stop();
    test_frame_num2();
    test_cfg_stop();
    test_geom();
    test_back_to_back();
    test_reset_mid_run();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
